// File: rtl/stdout_hex_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : stdout_hex_uart_if
// Description : Valid/ready word stream carrying stdout words from the core
//               to the hex UART printer.
//               master (producer): drives stdout_val_i, stdout_data_i;
//                                  observes stdout_rdy_o
//               slave  (printer) : observes stdout_val_i, stdout_data_i;
//                                  drives stdout_rdy_o
// Revision    : 1.0 - initial release
// ============================================================================
interface stdout_hex_uart_if;
    logic        stdout_val_i;
    logic [15:0] stdout_data_i;
    logic        stdout_rdy_o;

    modport master (
        output stdout_val_i,
        output stdout_data_i,
        input  stdout_rdy_o
    );

    modport slave (
        input  stdout_val_i,
        input  stdout_data_i,
        output stdout_rdy_o
    );
endinterface
`default_nettype wire

// File: rtl/stdout_hex_uart.sv
`default_nettype none
// ============================================================================
// Module      : stdout_hex_uart
// Description : Accepts one 16-bit stdout word per valid/ready handshake and
//               prints it on a UART 8N1 line as four uppercase ASCII hex
//               digits (MSB nibble first) followed by a line terminator.
//               Build macro STDOUT_CRLF_EN: terminator is CR LF (6 chars per
//               word) instead of LF only (5 chars per word).
// Ports       : clk_i      - system clock
//               rst_n      - asynchronous active-low reset
//               stdout     - word stream (slave modport): val, data, rdy
//               uart_tx_o  - serial line, idle high
//               busy_o     - high while any character of a word is in flight
// Parameters  : CLKS_PER_BIT - clk_i cycles per UART bit (>= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module stdout_hex_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic        clk_i,
    input  wire logic        rst_n,
    stdout_hex_uart_if.slave stdout,
    output logic             uart_tx_o,
    output logic             busy_o
);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("stdout_hex_uart: CLKS_PER_BIT must be >= 2");
    end

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

`ifdef STDOUT_CRLF_EN
    localparam logic [2:0] c_LAST_CHAR = 3'd5;
`else
    localparam logic [2:0] c_LAST_CHAR = 3'd4;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           r_char_idx;
    logic [15:0]          r_word;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   w_bit_cnt_nxt;
    logic [2:0]           w_bit_idx_nxt;
    logic [2:0]           w_char_idx_nxt;
    logic [15:0]          w_word_nxt;
    logic [7:0]           w_shift_nxt;
    logic                 w_tx_nxt;

    logic                 w_accept;
    logic                 w_bit_done;
    logic [3:0]           w_nibble;
    logic [7:0]           w_char;

    // Ready depends on registered state only, never on stdout_val_i.
    assign stdout.stdout_rdy_o = (r_state == S_IDLE);
    assign w_accept            = stdout.stdout_val_i && (r_state == S_IDLE);
    assign w_bit_done          = (r_bit_cnt == c_CNT_LAST);

    assign uart_tx_o = r_tx;
    assign busy_o    = r_busy;

    // ------------------------------------------------------------------------
    // Character currently being sent, selected by char_idx
    // ------------------------------------------------------------------------
    always_comb begin
        w_nibble = 4'h0;
        w_char   = 8'h0A;
        case (r_char_idx)
            3'd0:    w_nibble = r_word[15:12];
            3'd1:    w_nibble = r_word[11:8];
            3'd2:    w_nibble = r_word[7:4];
            3'd3:    w_nibble = r_word[3:0];
            default: w_nibble = 4'h0;
        endcase

        if (r_char_idx < 3'd4) begin
            // 'A' - 10 = 0x37, so letters map to 0x41..0x46
            if (w_nibble < 4'd10) begin
                w_char = 8'h30 + {4'h0, w_nibble};
            end else begin
                w_char = 8'h37 + {4'h0, w_nibble};
            end
        end else begin
`ifdef STDOUT_CRLF_EN
            w_char = (r_char_idx == 3'd4) ? 8'h0D : 8'h0A;
`else
            w_char = 8'h0A;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_char_idx_nxt = r_char_idx;
        w_word_nxt     = r_word;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt    = S_START;
                    w_word_nxt     = stdout.stdout_data_i;
                    w_char_idx_nxt = 3'd0;
                    w_bit_cnt_nxt  = '0;
                    w_bit_idx_nxt  = 3'd0;
                    w_tx_nxt       = 1'b0;
                end
            end

            S_START: begin
                if (w_bit_done) begin
                    // Character is resolved here, so the word register only
                    // needs to be stable from the accepting edge onwards.
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_shift_nxt   = w_char;
                    w_tx_nxt      = w_char[0];
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_bit_done) begin
                    w_bit_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt   = S_STOP;
                        w_bit_idx_nxt = 3'd0;
                        w_tx_nxt      = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                end
            end

            S_STOP: begin
                if (w_bit_done) begin
                    w_bit_cnt_nxt = '0;
                    if (r_char_idx < c_LAST_CHAR) begin
                        w_state_nxt    = S_START;
                        w_char_idx_nxt = r_char_idx + 3'd1;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_char_idx_nxt = 3'd0;
                        w_tx_nxt       = 1'b1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_char_idx <= 3'd0;
            r_word     <= 16'h0000;
            r_shift    <= 8'h00;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_char_idx <= w_char_idx_nxt;
            r_word     <= w_word_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stdout_hex_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_stdout_hex_uart
// Description : Directed self-checking bench for stdout_hex_uart with
//               CLKS_PER_BIT = 4. A line receiver decodes uart_tx_o into
//               bytes and checks each frame's shape; the main sequence drives
//               words and compares decoded bytes against hand-written values.
//               Expectations follow STDOUT_CRLF_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stdout_hex_uart;

    localparam int c_CPB = 4;
`ifdef STDOUT_CRLF_EN
    localparam int c_NCHARS = 6;
`else
    localparam int c_NCHARS = 5;
`endif
    localparam int c_WORD_CYC = c_NCHARS * 10 * c_CPB;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx_o;
    logic busy_o;

    stdout_hex_uart_if u_if ();

    stdout_hex_uart #(
        .CLKS_PER_BIT (c_CPB)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .stdout    (u_if),
        .uart_tx_o (uart_tx_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Line receiver: samples every cycle on the falling clock edge, requires
    // each bit to hold for exactly c_CPB samples, abandons a frame on reset.
    // ------------------------------------------------------------------------
    logic [7:0] rx_q[$];
    logic [9:0] rx_bits;
    bit         rx_ok;
    bit         rx_abort;

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_n === 1'b1 && uart_tx_o === 1'b0) begin
                rx_ok    = 1'b1;
                rx_abort = 1'b0;
                rx_bits  = '0;
                for (int b = 0; b < 10 && !rx_abort; b++) begin
                    for (int s = 0; s < c_CPB && !rx_abort; s++) begin
                        if (b != 0 || s != 0) @(negedge clk_i);
                        if (rst_n !== 1'b1) rx_abort = 1'b1;
                        else if (s == 0) rx_bits[b] = uart_tx_o;
                        else if (uart_tx_o !== rx_bits[b]) rx_ok = 1'b0;
                    end
                end
                if (!rx_abort) begin
                    // {bits held steady, start bit, stop bit} must be 3'b101
                    check("frame_shape", {29'd0, rx_ok, rx_bits[0], rx_bits[9]}, 32'd5);
                    rx_q.push_back(rx_bits[8:1]);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Expected byte helpers
    // ------------------------------------------------------------------------
    logic [7:0] exp_q[$];

    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic push_term();
`ifdef STDOUT_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF,
                  {24'd0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Counts falling edges with rdy low, starting at the current one.
    task automatic wait_rdy(output int n);
        n = 0;
        while (u_if.stdout_rdy_o !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    // Called on a falling edge while idle; returns on a falling edge after the
    // word has fully left the line.
    task automatic send_word(input logic [15:0] w);
        int n;
        check($sformatf("pre_rdy_%04h", w), {31'd0, u_if.stdout_rdy_o}, 32'd1);
        u_if.stdout_val_i  = 1'b1;
        u_if.stdout_data_i = w;
        @(negedge clk_i);
        u_if.stdout_val_i  = 1'b0;
        u_if.stdout_data_i = ~w;
        check($sformatf("tx_fall_%04h", w), {31'd0, uart_tx_o}, 32'd0);
        check($sformatf("busy_on_%04h", w), {31'd0, busy_o}, 32'd1);
        wait_rdy(n);
        check($sformatf("rdy_low_cyc_%04h", w), 32'(n), 32'(c_WORD_CYC));
        check($sformatf("busy_off_%04h", w), {31'd0, busy_o}, 32'd0);
        repeat (2) @(negedge clk_i);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int bad;

        u_if.stdout_val_i  = 1'b0;
        u_if.stdout_data_i = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_tx",   {31'd0, uart_tx_o},         32'd1);
        check("rst_rdy",  {31'd0, u_if.stdout_rdy_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o},            32'd0);
        rst_n = 1'b1;

        // Idle after reset with no valid
        bad = 0;
        repeat (1000) begin
            @(negedge clk_i);
            if (uart_tx_o !== 1'b1 || u_if.stdout_rdy_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // Single word 0x1A2F
        send_word(16'h1A2F);
        push4(8'h31, 8'h41, 8'h32, 8'h46);
        push_term();
        check_rx("w1A2F");

        // Back-to-back with valid held high
        u_if.stdout_val_i  = 1'b1;
        u_if.stdout_data_i = 16'h0000;
        @(negedge clk_i);
        u_if.stdout_data_i = 16'hFFFF;
        check("b2b_tx_fall1", {31'd0, uart_tx_o}, 32'd0);
        wait_rdy(n);
        check("b2b_cyc1", 32'(n), 32'(c_WORD_CYC));
        check("b2b_gap_tx", {31'd0, uart_tx_o}, 32'd1);
        @(negedge clk_i);
        check("b2b_accept2_rdy", {31'd0, u_if.stdout_rdy_o}, 32'd0);
        check("b2b_tx_fall2", {31'd0, uart_tx_o}, 32'd0);
        u_if.stdout_val_i  = 1'b0;
        u_if.stdout_data_i = 16'h1234;
        wait_rdy(n);
        check("b2b_cyc2", 32'(n), 32'(c_WORD_CYC));
        repeat (2) @(negedge clk_i);
        push4(8'h30, 8'h30, 8'h30, 8'h30);
        push_term();
        push4(8'h46, 8'h46, 8'h46, 8'h46);
        push_term();
        check_rx("b2b");

        // Reset during a data bit of char 2 of 0xBEEF
        u_if.stdout_val_i  = 1'b1;
        u_if.stdout_data_i = 16'hBEEF;
        @(negedge clk_i);
        u_if.stdout_val_i  = 1'b0;
        repeat (89) @(negedge clk_i);
        check("mid_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx",   {31'd0, uart_tx_o},         32'd1);
        check("mid_rst_rdy",  {31'd0, u_if.stdout_rdy_o}, 32'd1);
        check("mid_rst_busy", {31'd0, busy_o},            32'd0);
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk_i);
            if (uart_tx_o !== 1'b1 || u_if.stdout_rdy_o !== 1'b1) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h45);
        check_rx("beef_partial");

        send_word(16'h0007);
        push4(8'h30, 8'h30, 8'h30, 8'h37);
        push_term();
        check_rx("w0007");

        // Terminator check word
        send_word(16'h00C3);
        push4(8'h30, 8'h30, 8'h43, 8'h33);
        push_term();
        check_rx("w00C3");

        // All sixteen hex digits
        send_word(16'h0123);
        push4(8'h30, 8'h31, 8'h32, 8'h33);
        push_term();
        check_rx("w0123");
        send_word(16'h4567);
        push4(8'h34, 8'h35, 8'h36, 8'h37);
        push_term();
        check_rx("w4567");
        send_word(16'h89AB);
        push4(8'h38, 8'h39, 8'h41, 8'h42);
        push_term();
        check_rx("w89AB");
        send_word(16'hCDEF);
        push4(8'h43, 8'h44, 8'h45, 8'h46);
        push_term();
        check_rx("wCDEF");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
